// File: rtl/mul2_vec_fitness_scorer.sv
// Fitness scorer for an evolved bit-sliced 2x2-bit multiplier.
// Each beat carries WIDTH lanes of operands and the candidate's product bits.
// Matching product bits are counted against the golden product and summed
// over NUM_BATCHES beats. The total is then offered downstream as a score
// with a perfect flag, through a valid/ready handshake.
module mul2_vec_fitness_scorer #(
  parameter int WIDTH       = 16,
  parameter int NUM_BATCHES = 4,
  parameter int SCORE_W     = $clog2(4*WIDTH*NUM_BATCHES+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b1,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   y3,
  input  logic [WIDTH-1:0]   y2,
  input  logic [WIDTH-1:0]   y1,
  input  logic [WIDTH-1:0]   y0,
  output logic [SCORE_W-1:0] score,
  output logic               perfect,
  output logic               score_valid,
  input  logic               score_ready
);

  localparam int MASK_W    = 4*WIDTH;
  localparam int POP_W     = $clog2(MASK_W+1);
  localparam int BEAT_W    = $clog2(NUM_BATCHES+1);
  localparam int MAX_SCORE = 4*WIDTH*NUM_BATCHES;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beats_q;
  logic [SCORE_W-1:0]  acc_q;
  logic [MASK_W-1:0]   s1_mask_q;
  logic                s1_valid_q;
  logic                s2_valid_q;
  logic [SCORE_W-1:0]  score_q;
  logic                perfect_q;

  logic [WIDTH-1:0]    e3, e2, e1, e0;
  logic [MASK_W-1:0]   mask_d;
  logic [POP_W-1:0]    pop;
  logic                accept;
  logic                last_accept;
  logic                pipe_empty;
  logic                handshake;

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (beats_q == BEAT_W'(NUM_BATCHES-1));
  assign pipe_empty  = !s1_valid_q && !s2_valid_q;
  assign handshake   = (state_q == REPORT) && score_ready;

  assign in_ready    = (state_q == ACCUM) && (beats_q < BEAT_W'(NUM_BATCHES));
  assign score_valid = (state_q == REPORT);
  assign score       = score_q;
  assign perfect     = perfect_q;

  // Golden 2x2 product per lane and the per-bit agreement mask.
  always_comb begin
    e0     = a0 & b0;
    e1     = (a1 & b0) ^ (a0 & b1);
    e2     = a1 & b1 & ~(a0 & b0);
    e3     = a1 & a0 & b1 & b0;
    mask_d = {~(y3 ^ e3), ~(y2 ^ e2), ~(y1 ^ e1), ~(y0 ^ e0)};
  end

  // Count of matching bits in the registered stage-1 mask.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      pop = pop + POP_W'(s1_mask_q[i]);
    end
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (last_accept) state_d = DRAIN;
      DRAIN:   if (pipe_empty)  state_d = REPORT;
      REPORT:  if (score_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear) state_d = ACCUM;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Beat counter: counts accepts within one evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                beats_q <= '0;
    else if (clear)            beats_q <= '0;
    else if (handshake)        beats_q <= '0;
    else if (accept)           beats_q <= beats_q + 1'b1;
  end

  // Stage 1: capture the match mask of an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mask_q  <= '0;
    end else begin
      s1_valid_q <= accept && !clear;
      if (accept) s1_mask_q <= mask_d;
    end
  end

  // Stage 2: accumulate the popcount; s2_valid marks the beat as completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
    end else if (clear) begin
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (handshake)       acc_q <= '0;
      else if (s1_valid_q) acc_q <= acc_q + SCORE_W'(pop);
    end
  end

  // Result registers: loaded when DRAIN hands over to REPORT, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q   <= '0;
      perfect_q <= 1'b0;
    end else if (clear) begin
      score_q   <= '0;
      perfect_q <= 1'b0;
    end else if (state_q == DRAIN && pipe_empty) begin
      score_q   <= acc_q;
      perfect_q <= (acc_q == SCORE_W'(MAX_SCORE));
    end
  end

endmodule

// File: tb/tb_mul2_vec_fitness_scorer.sv
// Self-checking bench for mul2_vec_fitness_scorer (WIDTH=16, NUM_BATCHES=4).
// Expected scores come from an arithmetic multiply model and are queued when
// an evaluation's beats are driven, then popped when score_valid appears.
module tb_mul2_vec_fitness_scorer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a1 = '0, a0 = '0, b1 = '0, b0 = '0;
  logic [15:0] y3 = '0, y2 = '0, y1 = '0, y0 = '0;
  logic [8:0]  score;
  logic        perfect;
  logic        score_valid;
  logic        score_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  mul2_vec_fitness_scorer #(.WIDTH(16), .NUM_BATCHES(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .score(score), .perfect(perfect),
    .score_valid(score_valid), .score_ready(score_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Matching bits of one beat, using integer multiplication per lane.
  function automatic int beat_score(input logic [15:0] pa1, pa0, pb1, pb0,
                                    input logic [15:0] py3, py2, py1, py0);
    int s = 0;
    for (int i = 0; i < 16; i++) begin
      int a, b;
      logic [3:0] p;
      a = 2*int'(pa1[i]) + int'(pa0[i]);
      b = 2*int'(pb1[i]) + int'(pb0[i]);
      p = 4'(a*b);
      s += int'(p[3] == py3[i]) + int'(p[2] == py2[i])
         + int'(p[1] == py1[i]) + int'(p[0] == py0[i]);
    end
    return s;
  endfunction

  task automatic golden_y(input logic [15:0] pa1, pa0, pb1, pb0,
                          output logic [15:0] py3, py2, py1, py0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] p;
      p = 4'((2*int'(pa1[i]) + int'(pa0[i])) * (2*int'(pb1[i]) + int'(pb0[i])));
      py3[i] = p[3]; py2[i] = p[2]; py1[i] = p[1]; py0[i] = p[0];
    end
  endtask

  // mode 0: exhaustive golden, 1: all-zero y, 2: all-one y, 3: random noisy.
  task automatic make_beat(input int mode,
                           output logic [15:0] pa1, pa0, pb1, pb0,
                           output logic [15:0] py3, py2, py1, py0);
    pa1 = 16'hFF00; pa0 = 16'hF0F0; pb1 = 16'hCCCC; pb0 = 16'hAAAA;
    case (mode)
      0: begin py3 = 16'h8000; py2 = 16'h4C00; py1 = 16'h6AC0; py0 = 16'hA0A0; end
      1: begin py3 = '0; py2 = '0; py1 = '0; py0 = '0; end
      2: begin py3 = '1; py2 = '1; py1 = '1; py0 = '1; end
      default: begin
        pa1 = 16'($urandom); pa0 = 16'($urandom);
        pb1 = 16'($urandom); pb0 = 16'($urandom);
        golden_y(pa1, pa0, pb1, pb0, py3, py2, py1, py0);
        py3 ^= 16'($urandom & $urandom);
        py2 ^= 16'($urandom & $urandom);
        py1 ^= 16'($urandom & $urandom);
        py0 ^= 16'($urandom & $urandom & $urandom);
      end
    endcase
  endtask

  // Offer one beat and return #1 after the edge that accepted it.
  task automatic send_beat(input logic [15:0] pa1, pa0, pb1, pb0,
                           input logic [15:0] py3, py2, py1, py0);
    int n = 0;
    a1 = pa1; a0 = pa0; b1 = pb1; b0 = pb0;
    y3 = py3; y2 = py2; y1 = py1; y0 = py0;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (n >= 50) $display("FAIL accept_wait in_ready=%b required=1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_eval(input int mode);
    logic [15:0] va1, va0, vb1, vb0, vy3, vy2, vy1, vy0;
    int s = 0;
    for (int b = 0; b < 4; b++) begin
      make_beat(mode, va1, va0, vb1, vb0, vy3, vy2, vy1, vy0);
      s += beat_score(va1, va0, vb1, vb0, vy3, vy2, vy1, vy0);
      send_beat(va1, va0, vb1, vb0, vy3, vy2, vy1, vy0);
    end
    exp_q.push_back(s);
  endtask

  // Wait for the report, check latency/score, optionally stall, then consume.
  task automatic collect_result(input int hold);
    int n = 0;
    int e;
    while (score_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (n !== 3) $display("FAIL latency got=%0d required=3", n);
    else n_pass++;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty got=0 entries required>=1");
      return;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (score !== 9'(e)) $display("FAIL score got=%0d required=%0d", score, e);
    else n_pass++;
    n_checks++;
    if (perfect !== (e == 256)) $display("FAIL perfect got=%b required=%b", perfect, (e == 256));
    else n_pass++;
    for (int c = 0; c < hold; c++) begin
      a1 = 16'($urandom); a0 = 16'($urandom); y0 = 16'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (score !== 9'(e) || score_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL stall_hold got score=%0d valid=%b in_ready=%b required score=%0d valid=1 in_ready=0",
                 score, score_valid, in_ready, e);
      else n_pass++;
    end
    in_valid = 1'b0;
    score_ready = 1'b1;
    @(posedge clk); #1;
    score_ready = 1'b0;
    n_checks++;
    if (score_valid !== 1'b0 || in_ready !== 1'b1 || score !== 9'(e))
      $display("FAIL after_handshake got valid=%b in_ready=%b score=%0d required valid=0 in_ready=1 score=%0d",
               score_valid, in_ready, score, e);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (score_valid !== 1'b0 || score !== 9'd0 || perfect !== 1'b0)
      $display("FAIL reset_outputs got valid=%b score=%0d perfect=%b required 0/0/0",
               score_valid, score, perfect);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b required=1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_golden();
    run_eval(0);
    collect_result(0);
  endtask

  task automatic test_all_zero();
    run_eval(1);
    collect_result(0);
  endtask

  task automatic test_all_one();
    run_eval(2);
    collect_result(0);
  endtask

  task automatic test_backpressure();
    run_eval(0);
    collect_result(10);
    run_eval(1);
    collect_result(0);
  endtask

  task automatic test_clear_mid();
    logic [15:0] va1, va0, vb1, vb0, vy3, vy2, vy1, vy0;
    make_beat(0, va1, va0, vb1, vb0, vy3, vy2, vy1, vy0);
    send_beat(va1, va0, vb1, vb0, vy3, vy2, vy1, vy0);
    send_beat(va1, va0, vb1, vb0, vy3, vy2, vy1, vy0);
    in_valid = 1'b1;
    clear = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL clear_accept_ready got=%b required=1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (score !== 9'd0 || score_valid !== 1'b0 || perfect !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL after_clear got score=%0d valid=%b perfect=%b in_ready=%b required 0/0/0/1",
               score, score_valid, perfect, in_ready);
    else n_pass++;
    run_eval(1);
    collect_result(0);
  endtask

  task automatic test_async_reset_drain();
    logic [15:0] va1, va0, vb1, vb0, vy3, vy2, vy1, vy0;
    make_beat(0, va1, va0, vb1, vb0, vy3, vy2, vy1, vy0);
    for (int b = 0; b < 4; b++) send_beat(va1, va0, vb1, vb0, vy3, vy2, vy1, vy0);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL drain_in_ready got=%b required=0", in_ready);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (score_valid !== 1'b0 || score !== 9'd0)
      $display("FAIL async_reset got valid=%b score=%0d required valid=0 score=0", score_valid, score);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got=%b required=1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    run_eval(0);
    collect_result(0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      run_eval(3);
      collect_result(0);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_all_zero();
    test_all_one();
    test_backpressure();
    test_clear_mid();
    test_async_reset_drain();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
